instruction_prefetcher: RTL and testbench

- Sits between the CPU core's instruction-fetch port and instruction memory.
- Issues pipelined Avalon-MM reads ahead of execution and buffers the returned words with their PCs in a small FIFO.
- Presents them to the core on a valid/ready stream.
- A redirect from the core (branch, jump or trap) flushes the buffer and drops every read response still in flight.

---
 rtl/instruction_prefetcher_pkg.sv | 20 ++
 rtl/instruction_prefetcher_if.sv | 33 +++
 rtl/instruction_prefetcher_prefetch_fifo.sv | 63 ++++++
 rtl/instruction_prefetcher.sv | 183 ++++++++++++++++++
 tb/tb_instruction_prefetcher.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_prefetcher_pkg.sv
// Shared types for the instruction prefetcher slice.
package instruction_prefetcher_pkg;

   typedef logic [31:0] word;

   // One buffered fetch result: the address it came from and the word read.
   typedef struct packed {
      word pc;
      word ins;
   } fetch_entry_t;

   localparam logic [3:0] MEM_BE_ALL = 4'b1111;
   localparam word        WORD_BYTES = 32'd4;

   // Force a byte address onto a word boundary.
   function automatic word align_word(input word addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_prefetcher_if.sv
// Core-side instruction stream plus Avalon-MM read master signals.
// master: the prefetcher's view; slave: the core/memory environment's view.
interface instruction_prefetcher_if;
   import instruction_prefetcher_pkg::*;

   logic       redirect;
   word        redirect_pc;
   logic       ins_valid;
   logic       ins_ready;
   word        ins_data;
   word        ins_pc;
   logic       mem_read;
   word        mem_address;
   logic [3:0] mem_byteenable;
   logic       mem_waitrequest;
   word        mem_readdata;
   logic       mem_readdatavalid;

   modport master (
      input  redirect, redirect_pc, ins_ready,
      input  mem_waitrequest, mem_readdata, mem_readdatavalid,
      output ins_valid, ins_data, ins_pc,
      output mem_read, mem_address, mem_byteenable
   );

   modport slave (
      output redirect, redirect_pc, ins_ready,
      output mem_waitrequest, mem_readdata, mem_readdatavalid,
      input  ins_valid, ins_data, ins_pc,
      input  mem_read, mem_address, mem_byteenable
   );

endinterface

// File: rtl/instruction_prefetcher_prefetch_fifo.sv
// First-word-fall-through FIFO of fetch entries with synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module prefetch_fifo
   import instruction_prefetcher_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  fetch_entry_t             i_data,
   output fetch_entry_t             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_MAX);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   // Pointer and occupancy bookkeeping; flush wins over push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
         else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_ONE;
      end
   end

   // Entry storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/instruction_prefetcher.sv
// Instruction prefetcher: issues pipelined Avalon-MM reads ahead of the core,
// buffers responses with their PCs and streams them out on valid/ready.
// A redirect flushes the buffer and discards every response still in flight.
// Optional build macro: PREFETCH_PERF_EN adds perf_issued, perf_discarded and
// perf_stall_cycles counters.
module instruction_prefetcher
   import instruction_prefetcher_pkg::*;
#(
   parameter int unsigned DEPTH           = 4,
   parameter word         RESET_PC        = 32'h0000_0000,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   instruction_prefetcher_if.master  bus
`ifdef PREFETCH_PERF_EN
   ,
   output word                       perf_issued,
   output word                       perf_discarded,
   output word                       perf_stall_cycles
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
   localparam cnt_t MAXO_C  = cnt_t'(MAX_OUTSTANDING);
   localparam cnt_t ONE_C   = cnt_t'(1);

   word          r_fetch_pc;
   word          r_resp_pc;
   cnt_t         r_outstanding;
   cnt_t         r_discard;
   logic         r_mem_read;
   word          r_mem_address;
   logic         r_stale;

   logic         w_accept;
   logic         w_resp;
   logic         w_hold;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   cnt_t         w_count;
   word          w_redirect_pc;
   fetch_entry_t w_push_entry;
   fetch_entry_t w_head;

   cnt_t         w_out_next;
   cnt_t         w_count_next;
   cnt_t         w_discard_next;
   word          w_fetch_pc_next;
   word          w_resp_pc_next;
   logic         w_stale_next;
   logic         w_mem_read_next;
   word          w_mem_address_next;
   logic [CW:0]  w_inflight_next;

   assign w_accept      = r_mem_read && !bus.mem_waitrequest;
   assign w_hold        = r_mem_read && bus.mem_waitrequest;
   assign w_resp        = bus.mem_readdatavalid;
   assign w_push        = w_resp && (r_discard == '0) && !bus.redirect;
   assign w_pop         = !w_empty && bus.ins_ready && !bus.redirect;
   assign w_redirect_pc = align_word(bus.redirect_pc);
   assign w_push_entry  = '{pc: r_resp_pc, ins: bus.mem_readdata};

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect),
      .i_data  (w_push_entry),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.ins_valid      = !w_empty;
   assign bus.ins_data       = w_head.ins;
   assign bus.ins_pc         = w_head.pc;
   assign bus.mem_read       = r_mem_read;
   assign bus.mem_address    = r_mem_address;
   assign bus.mem_byteenable = MEM_BE_ALL;

   // Next-state for the read counters, fetch pointer and registered request.
   // mem_read/mem_address are registered from the post-edge counts, so the
   // request seen each cycle is the issue rule applied to current state. A
   // request stalled across a redirect is kept (stale) and, once accepted,
   // counts as discarded without advancing the new fetch PC.
   always_comb begin
      w_out_next = r_outstanding;
      if (w_accept && !w_resp)      w_out_next = r_outstanding + ONE_C;
      else if (w_resp && !w_accept) w_out_next = r_outstanding - ONE_C;

      w_count_next = w_count;
      if (bus.redirect)            w_count_next = '0;
      else if (w_push && !w_pop)   w_count_next = w_count + ONE_C;
      else if (w_pop && !w_push)   w_count_next = w_count - ONE_C;

      w_discard_next = r_discard;
      if (bus.redirect) begin
         w_discard_next = w_out_next;
      end else begin
         if (w_resp && (r_discard != '0)) w_discard_next = w_discard_next - ONE_C;
         if (w_accept && r_stale)         w_discard_next = w_discard_next + ONE_C;
      end

      w_fetch_pc_next = r_fetch_pc;
      if (bus.redirect)             w_fetch_pc_next = w_redirect_pc;
      else if (w_accept && !r_stale) w_fetch_pc_next = r_fetch_pc + WORD_BYTES;

      w_resp_pc_next = r_resp_pc;
      if (bus.redirect) w_resp_pc_next = w_redirect_pc;
      else if (w_push)  w_resp_pc_next = r_resp_pc + WORD_BYTES;

      w_stale_next = r_stale;
      if (bus.redirect) w_stale_next = w_hold;
      else if (w_accept) w_stale_next = 1'b0;

      w_inflight_next = {1'b0, w_count_next} + {1'b0, w_out_next};
      w_mem_read_next = w_hold ||
                        ((w_inflight_next < {1'b0, DEPTH_C}) && (w_out_next < MAXO_C));
      w_mem_address_next = w_hold ? r_mem_address : w_fetch_pc_next;
   end

   // Register fetch state and the Avalon request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_mem_read    <= 1'b0;
         r_mem_address <= '0;
         r_stale       <= 1'b0;
      end else begin
         r_fetch_pc    <= w_fetch_pc_next;
         r_resp_pc     <= w_resp_pc_next;
         r_outstanding <= w_out_next;
         r_discard     <= w_discard_next;
         r_mem_read    <= w_mem_read_next;
         r_mem_address <= w_mem_address_next;
         r_stale       <= w_stale_next;
      end
   end

   // The credit rule makes overflow impossible; catch it if that ever breaks.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      !(w_push && w_full));

`ifdef PREFETCH_PERF_EN
   word r_perf_issued;
   word r_perf_discarded;
   word r_perf_stall_cycles;

   // Free-running wrap-around counters for accepted reads, dropped responses
   // and cycles where the core wanted an instruction but none was buffered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_issued       <= '0;
         r_perf_discarded    <= '0;
         r_perf_stall_cycles <= '0;
      end else begin
         if (w_accept)
            r_perf_issued <= r_perf_issued + 32'd1;
         if (w_resp && (bus.redirect || (r_discard != '0)))
            r_perf_discarded <= r_perf_discarded + 32'd1;
         if (bus.ins_ready && w_empty)
            r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
   end

   assign perf_issued       = r_perf_issued;
   assign perf_discarded    = r_perf_discarded;
   assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Directed bench for instruction_prefetcher with a pipelined Avalon memory
// model returning mem[a] = a ^ 32'hFFFF_FFFF after a configurable latency.
module tb_instruction_prefetcher;
   import instruction_prefetcher_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instruction_prefetcher_if bus();

`ifdef PREFETCH_PERF_EN
   word perf_issued;
   word perf_discarded;
   word perf_stall_cycles;
`endif

   instruction_prefetcher #(
      .DEPTH           (4),
      .RESET_PC        (32'h0000_0000),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus)
`ifdef PREFETCH_PERF_EN
      ,
      .perf_issued       (perf_issued),
      .perf_discarded    (perf_discarded),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   // memory model state
   int unsigned lat = 1;
   int unsigned cyc = 0;
   int unsigned acc_cnt = 0;
   int unsigned stall_cnt = 0;
   word         q_addr[$];
   int unsigned q_due[$];

   // capture accepted reads and retire the response presented this cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         q_addr.delete();
         q_due.delete();
         acc_cnt   <= 0;
         stall_cnt <= 0;
      end else begin
         if (bus.mem_readdatavalid && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         if (bus.mem_read && !bus.mem_waitrequest) begin
            q_addr.push_back(bus.mem_address);
            q_due.push_back(cyc + 1 + lat);
            acc_cnt <= acc_cnt + 1;
         end
         if (bus.ins_ready && !bus.ins_valid) stall_cnt <= stall_cnt + 1;
      end
   end

   // present the oldest due response for the coming edge
   always @(negedge clk) begin
      if (rst && q_addr.size() > 0 && q_due[0] <= cyc + 1) begin
         bus.mem_readdatavalid = 1'b1;
         bus.mem_readdata      = q_addr[0] ^ 32'hFFFF_FFFF;
      end else begin
         bus.mem_readdatavalid = 1'b0;
         bus.mem_readdata      = '0;
      end
   end

   task automatic chk32(input string tag, input word obs, input word exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // reset with the given memory latency; returns at the negedge rst rises
   task automatic reset_dut(input int unsigned l, input logic rdy);
      @(negedge clk);
      rst = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.ins_ready = rdy;
      bus.mem_waitrequest = 1'b0;
      lat = l;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // wait (bounded) for the next delivered instruction and check it
   task automatic expect_next_ins(input string tag, input word pc);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (bus.ins_valid) begin
            found = 1'b1;
            chk32({tag, "_pc"}, bus.ins_pc, pc);
            chk32({tag, "_data"}, bus.ins_data, pc ^ 32'hFFFF_FFFF);
         end
      end
      chk1({tag, "_arrived"}, found, 1'b1);
   endtask

   initial begin
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.ins_ready = 1'b0;
      bus.mem_waitrequest = 1'b0;

      // 1: reset state, then zero-wait streaming from PC 0
      reset_dut(1, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_ins_valid", bus.ins_valid, 1'b0);
      chk1("rst_mem_read", bus.mem_read, 1'b0);
      chk32("rst_mem_address", bus.mem_address, 32'h0);
      chk32("byteenable", {28'h0, bus.mem_byteenable}, 32'hF);
      rst = 1'b1;
      @(negedge clk);
      chk1("s1_first_read", bus.mem_read, 1'b1);
      chk32("s1_first_addr", bus.mem_address, 32'h0);
      chk1("s1_valid_c1", bus.ins_valid, 1'b0);
      @(negedge clk);
      chk1("s1_valid_c2", bus.ins_valid, 1'b0);
      chk32("s1_addr_c2", bus.mem_address, 32'h4);
      @(negedge clk);
      chk1("s1_valid_c3", bus.ins_valid, 1'b1);
      chk32("s1_pc_c3", bus.ins_pc, 32'h0);
      chk32("s1_data_c3", bus.ins_data, 32'hFFFF_FFFF);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         chk1("s1_valid", bus.ins_valid, 1'b1);
         chk32("s1_pc", bus.ins_pc, 32'(4 * k));
         chk32("s1_data", bus.ins_data, ~32'(4 * k));
      end

      // 2: consumer stalled -> exactly DEPTH reads, then resume at 16
      reset_dut(1, 1'b0);
      repeat (7) @(negedge clk);
      chk1("s2_read_stopped", bus.mem_read, 1'b0);
      chk32("s2_accepted", acc_cnt, 32'd4);
      chk1("s2_valid", bus.ins_valid, 1'b1);
      chk32("s2_head0", bus.ins_pc, 32'h0);
      bus.ins_ready = 1'b1;
      @(negedge clk);
      chk32("s2_head1", bus.ins_pc, 32'h4);
      chk1("s2_resume_read", bus.mem_read, 1'b1);
      chk32("s2_resume_addr", bus.mem_address, 32'h10);
      for (int k = 2; k < 6; k++) begin
         @(negedge clk);
         chk1("s2_valid_k", bus.ins_valid, 1'b1);
         chk32("s2_head_k", bus.ins_pc, 32'(4 * k));
      end

      // 3: waitrequest held for 5 cycles on address 8
      reset_dut(1, 1'b1);
      repeat (3) @(negedge clk);
      chk32("s3_addr_before", bus.mem_address, 32'h8);
      bus.mem_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("s3_read_held", bus.mem_read, 1'b1);
         chk32("s3_addr_held", bus.mem_address, 32'h8);
      end
      bus.mem_waitrequest = 1'b0;
      @(negedge clk);
      chk32("s3_addr_after", bus.mem_address, 32'hC);
      expect_next_ins("s3_i8", 32'h8);
      expect_next_ins("s3_i12", 32'hC);
      expect_next_ins("s3_i16", 32'h10);

      // 4: latency 3, redirect with 3 reads outstanding
      reset_dut(3, 1'b1);
      repeat (3) @(negedge clk);
      chk1("s4_no_data_yet", bus.ins_valid, 1'b0);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h100;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk32("s4_new_addr", bus.mem_address, 32'h100);
      chk1("s4_new_read", bus.mem_read, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk1("s4_stale_dropped", bus.ins_valid, 1'b0);
         if (i < 3) @(negedge clk);
      end
      expect_next_ins("s4_i100", 32'h100);
      expect_next_ins("s4_i104", 32'h104);
      expect_next_ins("s4_i108", 32'h108);
`ifdef PREFETCH_PERF_EN
      chk32("s4_perf_discarded", perf_discarded, 32'd3);
      chk32("s4_perf_issued", perf_issued, acc_cnt);
      chk32("s4_perf_stall", perf_stall_cycles, stall_cnt);
`endif

      // 5: unaligned redirect coinciding with a response and a pop
      reset_dut(1, 1'b1);
      repeat (5) @(negedge clk);
      chk1("s5_valid_pre", bus.ins_valid, 1'b1);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h203;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk1("s5_flushed", bus.ins_valid, 1'b0);
      chk32("s5_aligned_addr", bus.mem_address, 32'h200);
      expect_next_ins("s5_i200", 32'h200);
      expect_next_ins("s5_i204", 32'h204);

      // 6: fetch address wraps modulo 2^32
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      bus.redirect = 1'b0;
      expect_next_ins("s6_iFFF8", 32'hFFFF_FFF8);
      expect_next_ins("s6_iFFFC", 32'hFFFF_FFFC);
      expect_next_ins("s6_i0", 32'h0);
      expect_next_ins("s6_i4", 32'h4);

      // 7: redirect while a request is stalled by waitrequest
      reset_dut(1, 1'b1);
      repeat (3) @(negedge clk);
      bus.mem_waitrequest = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h40;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk1("s7_read_kept", bus.mem_read, 1'b1);
      chk32("s7_addr_kept", bus.mem_address, 32'h8);
      @(negedge clk);
      chk32("s7_addr_kept2", bus.mem_address, 32'h8);
      bus.mem_waitrequest = 1'b0;
      @(negedge clk);
      chk32("s7_addr_new", bus.mem_address, 32'h40);
      expect_next_ins("s7_i40", 32'h40);
      expect_next_ins("s7_i44", 32'h44);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
